// File: rtl/sync_fifo_pkg.sv
// Shared constants, width helpers and the status-flag bundle for sync_fifo_param.
package sync_fifo_pkg;

    localparam int DEFAULT_DATA_W = 8;
    localparam int DEFAULT_DEPTH  = 16;

    function automatic int ptr_width(input int depth);
        return $clog2(depth);
    endfunction

    // One extra bit so the count can represent DEPTH itself.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    typedef struct packed {
        logic empty;
        logic full;
        logic almost_empty;
        logic almost_full;
        logic overflow;
        logic underflow;
    } fifo_status_t;

endpackage

// File: rtl/fifo_mem_2p.sv
// DEPTH x DATA_W storage: one synchronous write port, one read port that is
// registered by default or combinational when SYNC_FIFO_FWFT_EN is defined.
module fifo_mem_2p
    import sync_fifo_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int PTR_W  = ptr_width(DEFAULT_DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [PTR_W-1:0]  waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [PTR_W-1:0]  raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // NOTE: the storage array has no reset; only the pointers define which
    // entries are valid, and a reset branch here would prevent RAM inference.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    logic unused_fwft;

    assign unused_fwft = rst ^ re_i;
    assign rdata_o     = mem_q[raddr_i];
`else
    logic [DATA_W-1:0] rdata_q;

    // Reading the old array value on a same-address write keeps the head word
    // correct when a full FIFO reads and writes on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;
`endif

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO: pointers, occupancy count, flag decode and
// error pulses. Define SYNC_FIFO_FWFT_EN for first-word-fall-through output.
module sync_fifo_param
    import sync_fifo_pkg::*;
#(
    parameter int DATA_W   = DEFAULT_DATA_W,
    parameter int DEPTH    = DEFAULT_DEPTH,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr,
    input  logic [DATA_W-1:0]     data_in,
    input  logic                  rd,
    output logic [DATA_W-1:0]     data_out,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_empty,
    output logic                  almost_full,
    output logic [$clog2(DEPTH):0] fifo_cnt,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int PTR_W = ptr_width(DEPTH);
    localparam int CNT_W = cnt_width(DEPTH);

    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0] cnt_q,  cnt_d;
    logic             ovf_q,  ovf_d;
    logic             unf_q,  unf_d;
    logic             rd_acc, wr_acc;
    fifo_status_t     status;

    // Flags decode only the registered count, never wr/rd.
    always_comb begin
        status.empty        = (cnt_q == '0);
        status.full         = (cnt_q == CNT_W'(DEPTH));
        status.almost_empty = (cnt_q <= CNT_W'(AE_LEVEL));
        status.almost_full  = (cnt_q >= CNT_W'(AF_LEVEL));
        status.overflow     = ovf_q;
        status.underflow    = unf_q;
    end

    // NOTE: every always_comb output gets a default first so no path leaves a
    // signal unassigned and infers a latch.
    always_comb begin
        rd_acc = rd && !status.empty;
        wr_acc = wr && (!status.full || rd_acc);
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        ovf_d  = wr && !wr_acc;
        unf_d  = rd && !rd_acc;
        if (wr_acc) begin
            wptr_d = wptr_q + PTR_W'(1);
        end
        if (rd_acc) begin
            rptr_d = rptr_q + PTR_W'(1);
        end
        if (wr_acc && !rd_acc) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (rd_acc && !wr_acc) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
            ovf_q  <= ovf_d;
            unf_q  <= unf_d;
        end
    end

    fifo_mem_2p #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .PTR_W  (PTR_W)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .we_i    (wr_acc),
        .waddr_i (wptr_q),
        .wdata_i (data_in),
        .re_i    (rd_acc),
        .raddr_i (rptr_q),
        .rdata_o (data_out)
    );

    assign empty        = status.empty;
    assign full         = status.full;
    assign almost_empty = status.almost_empty;
    assign almost_full  = status.almost_full;
    assign overflow     = status.overflow;
    assign underflow    = status.underflow;
    assign fifo_cnt     = cnt_q;

endmodule
